// File: rtl/game_state_sequencer.sv
// Level sequencer for the map redraw FSM: owns gameState, issues one drawMap
// request per state change, advances on player action or an animation dwell.
module game_state_sequencer #(
   parameter int ANIM_CYCLES    = 25000000,
   parameter int TIMEOUT_CYCLES = 262143
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       action,
   input  logic       restart,
   input  logic       doneRedraw,
   output logic [3:0] gameState,
   output logic       drawMap,
   output logic       busy,
   output logic       timeoutFlag
);

   localparam int AW = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_CYCLES - 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      INITIAL         = 4'd0,
      UPDATE_BRIDGE_1 = 4'd1,
      FORMED_BRIDGE_1 = 4'd2,
      UPDATE_BRIDGE_2 = 4'd3,
      FORMED_BRIDGE_2 = 4'd4,
      UPDATE_BRIDGE_3 = 4'd5,
      FORMED_BRIDGE_3 = 4'd6,
      UPDATE_PILLAR   = 4'd7,
      PILLAR_RISED    = 4'd8,
      FINISHED_GAME   = 4'd9,
      DRAW_INITIAL    = 4'd10
   } level_e;

   typedef enum logic [2:0] {
      PH_REQ,
      PH_RELEASE,
      PH_RELEASE_RETRY,
      PH_DWELL,
      PH_WAIT_INPUT
   } phase_e;

   // [0],[1] synchronizer stages, [2] history for edge detection
   logic [2:0] act_sync_q;
   logic [2:0] rst_sync_q;
   logic       act_edge;
   logic       rst_edge;

   phase_e        phase_q, phase_d;
   level_e        level_q, level_d;
   logic          draw_q, draw_d;
   logic          tflag_q, tflag_d;
   logic [AW-1:0] dwell_q, dwell_d;
   logic [WW-1:0] wdog_q, wdog_d;

   function automatic level_e next_level(input level_e cur);
      case (cur)
         INITIAL:         next_level = UPDATE_BRIDGE_1;
         UPDATE_BRIDGE_1: next_level = FORMED_BRIDGE_1;
         FORMED_BRIDGE_1: next_level = UPDATE_BRIDGE_2;
         UPDATE_BRIDGE_2: next_level = FORMED_BRIDGE_2;
         FORMED_BRIDGE_2: next_level = UPDATE_BRIDGE_3;
         UPDATE_BRIDGE_3: next_level = FORMED_BRIDGE_3;
         FORMED_BRIDGE_3: next_level = UPDATE_PILLAR;
         UPDATE_PILLAR:   next_level = PILLAR_RISED;
         PILLAR_RISED:    next_level = FINISHED_GAME;
         FINISHED_GAME:   next_level = DRAW_INITIAL;
         DRAW_INITIAL:    next_level = INITIAL;
         default:         next_level = DRAW_INITIAL;
      endcase
   endfunction

   function automatic logic is_animated(input level_e cur);
      is_animated = (cur == UPDATE_BRIDGE_1) || (cur == UPDATE_BRIDGE_2) ||
                    (cur == UPDATE_BRIDGE_3) || (cur == UPDATE_PILLAR);
   endfunction

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         act_sync_q <= '0;
         rst_sync_q <= '0;
      end else begin
         act_sync_q <= {act_sync_q[1:0], action};
         rst_sync_q <= {rst_sync_q[1:0], restart};
      end
   end

   assign act_edge = act_sync_q[1] & ~act_sync_q[2];
   assign rst_edge = rst_sync_q[1] & ~rst_sync_q[2];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         phase_q <= PH_REQ;
         level_q <= DRAW_INITIAL;
         draw_q  <= 1'b0;
         tflag_q <= 1'b0;
         dwell_q <= '0;
         wdog_q  <= '0;
      end else begin
         phase_q <= phase_d;
         level_q <= level_d;
         draw_q  <= draw_d;
         tflag_q <= tflag_d;
         dwell_q <= dwell_d;
         wdog_q  <= wdog_d;
      end
   end

   // Level and drawMap are updated on the same edge, so the redraw FSM
   // always latches a stable gameState when it sees drawMap rise.
   always_comb begin
      phase_d = phase_q;
      level_d = level_q;
      draw_d  = draw_q;
      tflag_d = tflag_q;
      dwell_d = '0;
      wdog_d  = '0;

      if (rst_edge) begin
         level_d = DRAW_INITIAL;
         if (draw_q) begin
            phase_d = PH_RELEASE_RETRY;
            draw_d  = 1'b0;
         end else begin
            phase_d = PH_REQ;
            draw_d  = 1'b1;
         end
      end else begin
         case (phase_q)
            PH_REQ: begin
               draw_d = 1'b1;
               // drawMap is still low only on the first cycle out of reset
               if (draw_q) begin
                  if (doneRedraw) begin
                     phase_d = PH_RELEASE;
                     draw_d  = 1'b0;
                  end else if (wdog_q == WDOG_LAST) begin
                     tflag_d = 1'b1;
                     phase_d = PH_RELEASE_RETRY;
                     draw_d  = 1'b0;
                  end else begin
                     wdog_d = wdog_q + 1'b1;
                  end
               end
            end
            PH_RELEASE: begin
               if (is_animated(level_q)) begin
                  phase_d = PH_DWELL;
               end else if (level_q == DRAW_INITIAL) begin
                  level_d = INITIAL;
                  phase_d = PH_REQ;
                  draw_d  = 1'b1;
               end else begin
                  phase_d = PH_WAIT_INPUT;
               end
            end
            PH_RELEASE_RETRY: begin
               phase_d = PH_REQ;
               draw_d  = 1'b1;
            end
            PH_DWELL: begin
               if (dwell_q == ANIM_LAST) begin
                  level_d = next_level(level_q);
                  phase_d = PH_REQ;
                  draw_d  = 1'b1;
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
            PH_WAIT_INPUT: begin
               if (act_edge) begin
                  level_d = next_level(level_q);
                  phase_d = PH_REQ;
                  draw_d  = 1'b1;
               end
            end
            default: begin
               phase_d = PH_REQ;
               draw_d  = 1'b0;
            end
         endcase
      end
   end

   assign gameState   = level_q;
   assign drawMap     = draw_q;
   assign busy        = (phase_q != PH_WAIT_INPUT);
   assign timeoutFlag = tflag_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer with short dwell/watchdog settings.
module tb_game_state_sequencer;

   logic       clock;
   logic       resetn;
   logic       action;
   logic       restart;
   logic       doneRedraw;
   logic [3:0] gameState;
   logic       drawMap;
   logic       busy;
   logic       timeoutFlag;

   int n_checks = 0;
   int n_pass   = 0;
   bit auto_done = 1'b0;
   int hi_cnt = 0;

   game_state_sequencer #(
      .ANIM_CYCLES(4),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .action(action),
      .restart(restart),
      .doneRedraw(doneRedraw),
      .gameState(gameState),
      .drawMap(drawMap),
      .busy(busy),
      .timeoutFlag(timeoutFlag)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // redraw FSM stand-in: done three samples after drawMap rises
   initial begin
      forever begin
         @(negedge clock);
         if (auto_done) begin
            if (drawMap) begin
               hi_cnt++;
               if (hi_cnt >= 3) doneRedraw = 1'b1;
            end else begin
               hi_cnt = 0;
               doneRedraw = 1'b0;
            end
         end else begin
            hi_cnt = 0;
         end
      end
   end

   task automatic complete_redraw(input int wait_cycles);
      repeat (wait_cycles) tick();
      doneRedraw = 1'b1;
      tick();
      doneRedraw = 1'b0;
   endtask

   task automatic press_action();
      action = 1'b1;
      repeat (3) tick();
      action = 1'b0;
   endtask

   task automatic count_low(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (drawMap) break;
         n++;
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         tick();
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   int exp_seq [13] = '{10, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
   int seen [13];
   int rises;
   int changes;
   int lows;
   logic prev_draw;
   logic [3:0] prev_gs;

   initial begin
      resetn = 1'b1;
      action = 1'b0;
      restart = 1'b0;
      doneRedraw = 1'b0;
      #1 resetn = 1'b0;
      repeat (2) tick();

      // power-up
      check("rst_gs", 32'(gameState), 32'd10);
      check("rst_draw", 32'(drawMap), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_tflag", 32'(timeoutFlag), 32'd0);
      resetn = 1'b1;
      tick();
      check("pu_draw1", 32'(drawMap), 32'd1);
      check("pu_gs1", 32'(gameState), 32'd10);
      complete_redraw(4);
      check("pu_release", 32'(drawMap), 32'd0);
      tick();
      check("pu_draw2", 32'(drawMap), 32'd1);
      check("pu_gs2", 32'(gameState), 32'd0);
      complete_redraw(4);
      tick();
      check("pu_idle_busy", 32'(busy), 32'd0);
      check("pu_idle_gs", 32'(gameState), 32'd0);

      // action latency and dwell length
      action = 1'b1;
      tick();
      check("act_e1", 32'(gameState), 32'd0);
      tick();
      check("act_e2", 32'(drawMap), 32'd0);
      tick();
      check("act_e3_gs", 32'(gameState), 32'd1);
      check("act_e3_draw", 32'(drawMap), 32'd1);
      action = 1'b0;
      complete_redraw(3);
      check("dw_release", 32'(drawMap), 32'd0);
      count_low(lows);
      check("dw_len", 32'(lows), 32'd4);
      check("dw_gs", 32'(gameState), 32'd2);
      complete_redraw(3);
      tick();
      check("dw_idle", 32'(busy), 32'd0);

      // full walk-through from reset
      resetn = 1'b0;
      tick();
      check("walk_rst_gs", 32'(gameState), 32'd10);
      resetn = 1'b1;
      auto_done = 1'b1;
      rises = 0;
      prev_draw = drawMap;
      for (int cyc = 0; cyc < 2000 && rises < 13; cyc++) begin
         tick();
         if (drawMap && !prev_draw) begin
            seen[rises] = int'(gameState);
            rises++;
         end
         prev_draw = drawMap;
         action = !busy && (rises < 13);
      end
      action = 1'b0;
      check("walk_rises", 32'(rises), 32'd13);
      for (int i = 0; i < 13; i++)
         if (i < rises) check($sformatf("walk_seq%0d", i), 32'(seen[i]), 32'(exp_seq[i]));
      check("walk_tflag", 32'(timeoutFlag), 32'd0);
      wait_idle("walk_idle");

      // long hold: one advance only
      action = 1'b1;
      changes = 0;
      prev_gs = gameState;
      repeat (200) begin
         tick();
         if (gameState != prev_gs) changes++;
         prev_gs = gameState;
      end
      check("hold_changes", 32'(changes), 32'd2);
      check("hold_gs", 32'(gameState), 32'd2);
      check("hold_busy", 32'(busy), 32'd0);
      action = 1'b0;
      repeat (4) tick();
      auto_done = 1'b0;
      doneRedraw = 1'b0;

      // watchdog in state 3, with action pulses while busy
      press_action();
      check("wd_gs", 32'(gameState), 32'd3);
      check("wd_draw", 32'(drawMap), 32'd1);
      for (int i = 1; i <= 49; i++) begin
         action = (i == 5 || i == 10 || i == 20);
         tick();
      end
      action = 1'b0;
      check("wd_pre_draw", 32'(drawMap), 32'd1);
      check("wd_pre_tflag", 32'(timeoutFlag), 32'd0);
      tick();
      check("wd_low_draw", 32'(drawMap), 32'd0);
      check("wd_tflag", 32'(timeoutFlag), 32'd1);
      check("wd_low_gs", 32'(gameState), 32'd3);
      tick();
      check("wd_retry_draw", 32'(drawMap), 32'd1);
      check("wd_retry_gs", 32'(gameState), 32'd3);
      complete_redraw(2);
      count_low(lows);
      check("wd_dw_len", 32'(lows), 32'd4);
      check("wd_dw_gs", 32'(gameState), 32'd4);
      complete_redraw(1);
      tick();
      check("wd_idle_busy", 32'(busy), 32'd0);
      check("wd_idle_gs", 32'(gameState), 32'd4);
      check("wd_sticky", 32'(timeoutFlag), 32'd1);

      // restart mid-redraw in state 5
      press_action();
      check("rs_gs5", 32'(gameState), 32'd5);
      tick();
      restart = 1'b1;
      tick();
      tick();
      check("rs_wait_gs", 32'(gameState), 32'd5);
      tick();
      check("rs_low_draw", 32'(drawMap), 32'd0);
      check("rs_low_gs", 32'(gameState), 32'd10);
      restart = 1'b0;
      tick();
      check("rs_req_draw", 32'(drawMap), 32'd1);
      check("rs_req_gs", 32'(gameState), 32'd10);
      check("rs_tflag", 32'(timeoutFlag), 32'd1);
      complete_redraw(1);
      tick();
      check("rs_gs0", 32'(gameState), 32'd0);
      complete_redraw(1);
      tick();
      press_action();
      check("ar_gs1", 32'(gameState), 32'd1);
      complete_redraw(1);
      tick();
      tick();
      check("ar_dwell_draw", 32'(drawMap), 32'd0);

      // asynchronous reset mid-dwell
      #2 resetn = 1'b0;
      #1;
      check("ar_gs", 32'(gameState), 32'd10);
      check("ar_draw", 32'(drawMap), 32'd0);
      check("ar_busy", 32'(busy), 32'd1);
      check("ar_tflag", 32'(timeoutFlag), 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      check("ar_restart_draw", 32'(drawMap), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/game_state_sequencer.md
Name: game_state_sequencer

Overview:
- Upstream controller for the map redraw FSM. It owns the 4-bit gameState and walks the level sequence from DRAW_INITIAL to FINISHED_GAME.
- For every state change it issues a full-screen redraw request (drawMap) and holds it until doneRedraw returns.
- It advances on player action presses, or on a dwell timer for the animated UPDATE_* states.
- It provides a redraw watchdog with retry.

Parameters:
- ANIM_CYCLES, 25000000, dwell in cycles after an UPDATE_* redraw completes before auto-advancing to its FORMED/RISED state (min 1).
- TIMEOUT_CYCLES, 262143, maximum cycles drawMap may stay high without doneRedraw before a retry (min 2).

Ports:
- clock  in  1  system clock, all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- action  in  1  raw player step button, active-high level, asynchronous to clock
- restart  in  1  raw restart button, active-high level, asynchronous to clock
- doneRedraw  in  1  redraw FSM completion; high from end of draw until drawMap drops
- gameState  out  4  current state code to the redraw FSM
- drawMap  out  1  redraw request, level; held until doneRedraw seen
- busy  out  1  high whenever phase is not WAIT_INPUT
- timeoutFlag  out  1  sticky; set on first watchdog expiry

Behaviour:
- State codes (fixed): INITIAL=0, UPDATE_BRIDGE_1=1, FORMED_BRIDGE_1=2, UPDATE_BRIDGE_2=3, FORMED_BRIDGE_2=4, UPDATE_BRIDGE_3=5, FORMED_BRIDGE_3=6, UPDATE_PILLAR=7, PILLAR_RISED=8, FINISHED_GAME=9, DRAW_INITIAL=10. Codes 11-15 are never output.
- Reset (async, resetn=0):
  - gameState=10, drawMap=0, busy=1, timeoutFlag=0, all counters 0, synchronizers 0.
  - Phase=REQ.
  - drawMap=1 is set on the first rising edge with resetn=1.
- Input conditioning:
  - action and restart each pass through a 2-flop synchronizer plus a history flop.
  - The edge pulse is high for one cycle when sync=1 and history=0.
  - Net effect: from the first edge sampling the input high, gameState/drawMap change on the 3rd edge.
- Phases:
  - REQ:
    - drawMap=1; watchdog counts.
    - doneRedraw=1 -> RELEASE.
    - Watchdog reaches TIMEOUT_CYCLES-1 -> timeoutFlag<=1, RELEASE_RETRY.
  - RELEASE:
    - drawMap=0 for exactly 1 cycle, so the redraw FSM returns to idle.
    - Next phase: DWELL if gameState is 1, 3, 5 or 7; if gameState=10, set gameState<=0 and go to REQ; otherwise WAIT_INPUT.
  - RELEASE_RETRY: drawMap=0 for 1 cycle, then REQ with gameState unchanged and watchdog cleared.
  - DWELL:
    - Counter runs 0..ANIM_CYCLES-1.
    - At terminal count: gameState<=gameState+1, REQ.
  - WAIT_INPUT:
    - busy=0.
    - Action edge: gameState 0->1, 2->3, 4->5, 6->7, 8->9; FINISHED_GAME(9) -> 10. Then REQ.
- drawMap and gameState register together: gameState never changes while drawMap=1, and never in the same cycle drawMap rises.
- Action edges arriving while busy=1 are discarded, not queued.
- Restart edge has priority over action and over every phase:
  - gameState<=10, counters cleared.
  - If drawMap=1, go through RELEASE_RETRY-style single low cycle, then REQ. Otherwise go directly to REQ.
  - timeoutFlag is not cleared.
- Simultaneous doneRedraw and watchdog terminal in REQ: doneRedraw wins; no timeout is flagged.
- doneRedraw outside REQ is ignored.
- Counters are sized by $clog2 of their parameter. No wrap is possible, because every terminal count clears the counter.

Test Plan:
- Power-up (ANIM_CYCLES=4, TIMEOUT_CYCLES=50): release resetn, doneRedraw 5 cycles after drawMap rises.
  -> drawMap high 1st edge with gameState=10; low 1 cycle; high again with gameState=0.
  -> After second done: busy=0, gameState=0.
- Action pulse in INITIAL.
  -> gameState=1 and drawMap=1 on 3rd edge.
  -> After done: 1 low cycle, then exactly 4 dwell cycles, then gameState=2 with drawMap=1.
- Full walk-through: a bench model answers each drawMap with doneRedraw after 3 cycles, and presses action whenever busy=0.
  -> gameState sequence 10,0,1,2,3,4,5,6,7,8,9,10,0; timeoutFlag=0.
- Action held 200 cycles and extra pulses during busy.
  -> Exactly one advance per rising edge accepted in WAIT_INPUT; busy-time pulses cause no change.
- Watchdog: never assert doneRedraw in state 3.
  -> After 50 cycles: timeoutFlag=1, drawMap low 1 cycle, re-request with gameState=3.
  -> A later done proceeds normally; timeoutFlag stays 1.
- Restart mid-redraw in state 5, plus an async resetn pulse mid-DWELL.
  -> Restart: drawMap low 1 cycle, then high with gameState=10.
  -> resetn: outputs immediately return to reset values without waiting for a clock edge.
